// File: rtl/matser.sv
// Matrix result serializer: captures a ROWS x COLS matrix through a valid/ready
// handshake and streams its elements in row-major order, one per accepted beat.
module matser #(
    parameter int ROWS  = 1,
    parameter int COLS  = 1,
    parameter int WIDTH = 16,
    localparam int RW   = $clog2(ROWS + 1),
    localparam int CW   = $clog2(COLS + 1)
) (
    input  logic                              clk,
    input  logic                              reset_l,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0]  in_mat,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [RW-1:0]                     out_row,
    output logic [CW-1:0]                     out_col,
    output logic                              out_last
);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS);

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [RW-1:0]                      r_row;
    logic [RW-1:0]                      w_row_nxt;
    logic [CW-1:0]                      r_col;
    logic [CW-1:0]                      w_col_nxt;
    logic [ROWS:1][COLS:1][WIDTH-1:0]   r_mat;
    logic                               w_at_last;
    logic                               w_out_fire;
    logic                               w_in_fire;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= S_IDLE;
            r_row   <= ROW_ONE;
            r_col   <= COL_ONE;
            r_mat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            if (w_in_fire) begin
                r_mat <= in_mat;
            end
        end
    end

    // A capture always restarts at (1,1); the final beat also rewinds the
    // counters so they never step past ROWS/COLS.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        if (w_in_fire) begin
            w_state_nxt = S_STREAM;
            w_row_nxt   = ROW_ONE;
            w_col_nxt   = COL_ONE;
        end else if (w_out_fire) begin
            if (w_at_last) begin
                w_state_nxt = S_IDLE;
                w_row_nxt   = ROW_ONE;
                w_col_nxt   = COL_ONE;
            end else if (r_col == COL_LAST) begin
                w_row_nxt   = r_row + ROW_ONE;
                w_col_nxt   = COL_ONE;
            end else begin
                w_col_nxt   = r_col + COL_ONE;
            end
        end
    end

    // in_ready reopens on the final accepted beat for zero-bubble back-to-back.
    always_comb begin
        w_at_last  = (r_row == ROW_LAST) && (r_col == COL_LAST);
        out_valid  = (r_state == S_STREAM);
        out_last   = out_valid & w_at_last;
        out_data   = out_valid ? r_mat[r_row][r_col] : '0;
        out_row    = r_row;
        out_col    = r_col;
        w_out_fire = out_valid & out_ready;
        in_ready   = (r_state == S_IDLE) | (w_out_fire & w_at_last);
        w_in_fire  = in_valid & in_ready;
    end

endmodule
